// File: rtl/calc_pkg.sv
// calc_pkg: shared definitions between the calculator core and its display.
// Holds the status encoding, special digit codes and 7-segment patterns
// ({g,f,e,d,c,b,a}, active-low).
package calc_pkg;

  typedef enum logic [1:0] {
    ST_ERRO    = 2'b00,
    ST_PRONTA  = 2'b01,
    ST_OCUPADA = 2'b10,
    ST_IMPRIME = 2'b11
  } status_t;

  localparam logic [3:0] DIG_MINUS = 4'hA;
  localparam logic [3:0] DIG_BLANK = 4'hF;

  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;
  localparam logic [6:0] SEG_R     = 7'b0101111;

  // Codes B..F never light anything; they count as "blank" for zero blanking.
  function automatic logic is_blank_code(input logic [3:0] code);
    return code >= 4'hB;
  endfunction

endpackage

// File: rtl/display_scan_if.sv
// display_scan_if: the core's status/pos/dig stream into the display.
// The core drives through the master modport, the display listens on slave.
interface display_scan_if;
  import calc_pkg::*;

  status_t    status;
  logic [3:0] pos;
  logic [3:0] dig;

  modport master (output status, output pos, output dig);
  modport slave  (input  status, input  pos, input  dig);

endinterface

// File: rtl/seg7_decoder.sv
// seg7_decoder: maps a 4-bit digit code to an active-low {g..a} pattern.
// 0-9 are decimal, A is minus, B-F are blank.
module seg7_decoder
  import calc_pkg::*;
(
  input  logic [3:0] code,
  output logic [6:0] pattern
);

  // Pure lookup; anything outside 0-9 and minus shows nothing.
  always_comb begin
    pattern = SEG_BLANK;
    case (code)
      4'h0:      pattern = SEG_0;
      4'h1:      pattern = SEG_1;
      4'h2:      pattern = SEG_2;
      4'h3:      pattern = SEG_3;
      4'h4:      pattern = SEG_4;
      4'h5:      pattern = SEG_5;
      4'h6:      pattern = SEG_6;
      4'h7:      pattern = SEG_7;
      4'h8:      pattern = SEG_8;
      4'h9:      pattern = SEG_9;
      DIG_MINUS: pattern = SEG_MINUS;
      default:   pattern = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/display_scan.sv
// display_scan: captures digits the core prints and scans them onto an
// active-low common-anode 7-segment bank. Shows "Err" while the core is in
// ERRO and lights the rightmost decimal point while it is busy.
// Optional build macro: DISPLAY_SCAN_LZB_EN enables leading-zero blanking.
module display_scan
  import calc_pkg::*;
#(
  parameter int NUM_DIGITS  = 8,
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clock,
  input  logic                  reset,
  display_scan_if.slave         bus,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam int DIV_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);

  logic [3:0]       digit_buf [NUM_DIGITS];
  status_t          prev_status;
  logic [DIV_W-1:0] div_cnt;
  logic [IDX_W-1:0] scan_idx;

  logic       frame_start;
  logic       pos_valid;
  logic [3:0] scan_code;
  logic [3:0] shown_code;
  logic [6:0] decoded;
  logic [6:0] err_pattern;

  assign frame_start = (bus.status == ST_IMPRIME) && (prev_status != ST_IMPRIME);
  assign pos_valid   = {1'b0, bus.pos} < 5'(NUM_DIGITS);

  // Digit buffer: a new print frame blanks everything, then the same-edge
  // write lands on top; ERRO keeps the buffer blank; other states hold.
  always_ff @(posedge clock) begin
    if (reset) begin
      prev_status <= ST_PRONTA;
      for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= DIG_BLANK;
    end else begin
      prev_status <= bus.status;
      case (bus.status)
        ST_ERRO: begin
          for (int i = 0; i < NUM_DIGITS; i++) digit_buf[i] <= DIG_BLANK;
        end
        ST_IMPRIME: begin
          for (int i = 0; i < NUM_DIGITS; i++) begin
            if (frame_start) digit_buf[i] <= DIG_BLANK;
            if (pos_valid && bus.pos == 4'(i)) digit_buf[i] <= bus.dig;
          end
        end
        default: ;
      endcase
    end
  end

  // Refresh divider and scan position; the position steps on each divider wrap.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_cnt  <= '0;
      scan_idx <= '0;
    end else if (div_cnt == DIV_LAST) begin
      div_cnt  <= '0;
      scan_idx <= (scan_idx == IDX_LAST) ? '0 : scan_idx + 1'b1;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  // Select the code stored at the position currently being scanned.
  always_comb begin
    scan_code = DIG_BLANK;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) scan_code = digit_buf[i];
    end
  end

`ifdef DISPLAY_SCAN_LZB_EN
  logic [NUM_DIGITS-1:0] lead_blank;
  logic                  above_empty;
  logic                  scan_lzb;

  // A zero is "leading" when nothing above it shows a non-zero symbol;
  // position 0 is never blanked so a lone zero still appears.
  always_comb begin
    lead_blank  = '0;
    above_empty = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      if (above_empty && digit_buf[i] == 4'h0) lead_blank[i] = 1'b1;
      above_empty = above_empty &&
                    (digit_buf[i] == 4'h0 || is_blank_code(digit_buf[i]));
    end
  end

  // Pick the blanking decision for the scanned position and apply it.
  always_comb begin
    scan_lzb = 1'b0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (scan_idx == IDX_W'(i)) scan_lzb = lead_blank[i];
    end
    shown_code = scan_lzb ? DIG_BLANK : scan_code;
  end
`else
  assign shown_code = scan_code;
`endif

  seg7_decoder u_decoder (
    .code    (shown_code),
    .pattern (decoded)
  );

  // "Err" override: E on position 2, r on positions 1 and 0, rest dark.
  always_comb begin
    err_pattern = SEG_BLANK;
    if (scan_idx == IDX_W'(2))     err_pattern = SEG_E;
    else if (scan_idx < IDX_W'(2)) err_pattern = SEG_R;
  end

  // Registered drive of the display pins from the current scan position.
  always_ff @(posedge clock) begin
    if (reset) begin
      an  <= '1;
      seg <= SEG_BLANK;
      dp  <= 1'b1;
    end else begin
      an  <= ~(NUM_DIGITS'(1) << scan_idx);
      seg <= (bus.status == ST_ERRO) ? err_pattern : decoded;
      dp  <= !((bus.status == ST_OCUPADA) && (scan_idx == '0));
    end
  end

endmodule

// File: tb/tb_display_scan.sv
// tb_display_scan: randomized self-checking bench for display_scan.
// Two instances share one bus: an 8-digit bank dividing by 4 and a 3-digit
// bank refreshing every cycle. Honours DISPLAY_SCAN_LZB_EN in its model.
module tb_display_scan;
  import calc_pkg::*;

  localparam int N_A = 8;
  localparam int DIV_A = 4;
  localparam int N_B = 3;
  localparam int DIV_B = 1;

  logic clock = 1'b0;
  logic reset = 1'b1;

  display_scan_if bus ();

  logic [N_A-1:0] an_a;
  logic [6:0]     seg_a;
  logic           dp_a;
  logic [N_B-1:0] an_b;
  logic [6:0]     seg_b;
  logic           dp_b;

  display_scan #(.NUM_DIGITS(N_A), .REFRESH_DIV(DIV_A)) dut_a (
    .clock (clock), .reset (reset), .bus (bus), .an (an_a), .seg (seg_a), .dp (dp_a)
  );

  display_scan #(.NUM_DIGITS(N_B), .REFRESH_DIV(DIV_B)) dut_b (
    .clock (clock), .reset (reset), .bus (bus), .an (an_b), .seg (seg_b), .dp (dp_b)
  );

  always #5 clock = ~clock;

  // Observed pins of each instance packed as {an (16, zero-extended), seg, dp}.
  logic [23:0] act_out [2];
  assign act_out[0] = {8'h00, an_a, seg_a, dp_a};
  assign act_out[1] = {13'h0000, an_b, seg_b, dp_b};

  int          cfg_n   [2] = '{N_A, N_B};
  int          cfg_div [2] = '{DIV_A, DIV_B};
  logic [3:0]  mbuf    [2][16];
  logic [6:0]  seg_tab [16];
  logic [6:0]  pat_e;
  logic [6:0]  pat_r;
  status_t     mprev;
  int          edges;
  logic [23:0] exp_out [2];
  int          tests_run;
  int          tests_failed;

  // Expected pins after an edge, from the model state before that edge.
  function automatic logic [23:0] expect_out(input int k, input status_t st);
    int         n;
    int         idx;
    logic [15:0] a;
    logic [3:0] code;
    logic [6:0] s;
    logic       d;
    logic       all_empty;
    n   = cfg_n[k];
    idx = ((edges - 1) / cfg_div[k]) % n;
    a   = 16'((1 << n) - 1) & ~16'(1 << idx);
    if (st == ST_ERRO) begin
      if (idx == 2)     s = pat_e;
      else if (idx < 2) s = pat_r;
      else              s = 7'b1111111;
    end else begin
      code = mbuf[k][idx];
`ifdef DISPLAY_SCAN_LZB_EN
      if (idx > 0 && code == 4'h0) begin
        all_empty = 1'b1;
        for (int j = idx + 1; j < n; j++)
          if (!(mbuf[k][j] == 4'h0 || mbuf[k][j] >= 4'hB)) all_empty = 1'b0;
        if (all_empty) code = 4'hF;
      end
`else
      all_empty = 1'b0;
`endif
      s = seg_tab[code];
    end
    d = (st == ST_OCUPADA && idx == 0) ? 1'b0 : 1'b1;
    return {a, s, d};
  endfunction

  // Drive one cycle, compute expectations, then advance the model.
  task automatic step(input status_t st, input logic [3:0] p, input logic [3:0] d);
    @(negedge clock);
    reset      = 1'b0;
    bus.status = st;
    bus.pos    = p;
    bus.dig    = d;
    @(posedge clock);
    edges++;
    for (int k = 0; k < 2; k++) begin
      exp_out[k] = expect_out(k, st);
      if (st == ST_ERRO) begin
        for (int j = 0; j < 16; j++) mbuf[k][j] = 4'hF;
      end else if (st == ST_IMPRIME) begin
        if (mprev != ST_IMPRIME)
          for (int j = 0; j < 16; j++) mbuf[k][j] = 4'hF;
        if (int'(p) < cfg_n[k]) mbuf[k][p] = d;
      end
    end
    mprev = st;
    #1;
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clock);
    reset      = 1'b1;
    bus.status = ST_PRONTA;
    repeat (cycles) @(posedge clock);
    #1;
    edges = 0;
    mprev = ST_PRONTA;
    for (int k = 0; k < 2; k++)
      for (int j = 0; j < 16; j++) mbuf[k][j] = 4'hF;
  endtask

  task automatic test_reset();
    do_reset(5);
    tests_run++;
    if (act_out[0] !== {16'h00FF, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset dut0: got %h, want %h", act_out[0], {16'h00FF, 7'h7F, 1'b1});
    end
    tests_run++;
    if (act_out[1] !== {16'h0007, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL reset dut1: got %h, want %h", act_out[1], {16'h0007, 7'h7F, 1'b1});
    end
  endtask

  task automatic test_frame_write();
    step(ST_IMPRIME, 4'd0, 4'd3);
    step(ST_IMPRIME, 4'd1, 4'd2);
    for (int c = 0; c < 70; c++) begin
      step(ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL frame_write dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_frame_clear();
    step(ST_IMPRIME, 4'd0, 4'd7);
    step(ST_IMPRIME, 4'd0, 4'd1);
    for (int c = 0; c < 40; c++) begin
      step(ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL frame_clear dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_out_of_range();
    step(ST_IMPRIME, 4'd2, 4'd6);
    step(ST_IMPRIME, 4'd9, 4'($urandom));
    step(ST_IMPRIME, 4'(8 + $urandom_range(0, 7)), 4'($urandom));
    step(ST_IMPRIME, 4'd1, 4'(11 + $urandom_range(0, 4)));
    for (int c = 0; c < 40; c++) begin
      step(ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL out_of_range dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_error();
    step(ST_IMPRIME, 4'd0, 4'd8);
    step(ST_IMPRIME, 4'd3, 4'hA);
    for (int c = 0; c < 80; c++) begin
      step((c < 40) ? ST_ERRO : ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL error dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_lzb();
    step(ST_IMPRIME, 4'd2, 4'd0);
    step(ST_IMPRIME, 4'd1, 4'd0);
    step(ST_IMPRIME, 4'd0, 4'd0);
    for (int c = 0; c < 40; c++) begin
      step(ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL lzb_zeros dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
    step(ST_IMPRIME, 4'd2, 4'd5);
    step(ST_IMPRIME, 4'd1, 4'd0);
    step(ST_IMPRIME, 4'd4, 4'hA);
    step(ST_IMPRIME, 4'd3, 4'd0);
    for (int c = 0; c < 40; c++) begin
      step(ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL lzb_inner dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_busy();
    for (int c = 0; c < 40; c++) begin
      step(ST_OCUPADA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL busy dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    step(ST_IMPRIME, 4'd0, 4'd9);
    step(ST_IMPRIME, 4'd1, 4'd4);
    do_reset(1);
    tests_run++;
    if (act_out[0] !== {16'h00FF, 7'h7F, 1'b1}) begin
      tests_failed++;
      $display("[TB] FAIL mid_reset dut0: got %h, want %h", act_out[0], {16'h00FF, 7'h7F, 1'b1});
    end
    step(ST_IMPRIME, 4'd2, 4'd1);
    for (int c = 0; c < 40; c++) begin
      step(ST_PRONTA, 4'($urandom), 4'($urandom));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL mid_reset_frame dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 1500; c++) begin
      int r;
      status_t st;
      r  = $urandom_range(0, 9);
      st = (r < 5) ? ST_IMPRIME : (r < 7) ? ST_PRONTA : (r < 9) ? ST_OCUPADA : ST_ERRO;
      step(st, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int k = 0; k < 2; k++) begin
        tests_run++;
        if (act_out[k] !== exp_out[k]) begin
          tests_failed++;
          $display("[TB] FAIL random dut%0d edge %0d: got %h, want %h", k, edges, act_out[k], exp_out[k]);
        end
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edges        = 0;
    mprev        = ST_PRONTA;
    bus.status   = ST_PRONTA;
    bus.pos      = 4'd0;
    bus.dig      = 4'd0;
    seg_tab = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                7'b0000000, 7'b0010000, 7'b0111111, 7'b1111111,
                7'b1111111, 7'b1111111, 7'b1111111, 7'b1111111};
    pat_e = 7'b0000110;
    pat_r = 7'b0101111;

    test_reset();
    test_frame_write();
    test_frame_clear();
    test_out_of_range();
    test_error();
    test_lzb();
    test_busy();
    test_reset_mid_frame();
    test_back_to_back();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/display_scan.md
# display_scan

Downstream consumer of the calculator core's `status`/`pos`/`dig` stream. It captures digit writes into a per-position buffer while the core is in the print state and time-multiplexes the buffer onto an active-low, common-anode 7-segment bank. It also shows a fixed error pattern and a busy indicator.

## Interface
Parameters:
- `NUM_DIGITS`, default 8: number of display positions; legal range 3..16.
- `REFRESH_DIV`, default 50000: clock cycles per scanned digit; must be ≥1.

Ports:
- `clock`  in  1: system clock.
- `reset`  in  1: reset, synchronous, active-high.
- `status`  in  2: core status; 00 ERRO, 01 PRONTA, 10 OCUPADA, 11 IMPRIME.
- `pos`  in  4: target position; 0 is the rightmost digit.
- `dig`  in  4: digit code. 0–9 are decimal, 4'hA is minus, 4'hB–4'hF are blank.
- `an`  out  NUM_DIGITS: anode enables, active-low, one-hot.
- `seg`  out  7: segments {g,f,e,d,c,b,a}, active-low.
- `dp`  out  1: decimal point, active-low.

## Operation
- Buffer: `NUM_DIGITS` × 4-bit codes; every entry resets to 4'hF (blank).
- `prev_status` register; reset value 01.
- Frame start: `status`==IMPRIME while `prev_status`!=IMPRIME.
  - All entries become blank.
  - `buf[pos]` takes `dig` on the same edge; the write wins over the clear.
- While `status`==IMPRIME (including the frame-start cycle): every cycle with `pos`<`NUM_DIGITS` writes `buf[pos]`<=`dig`.
  - Writes with `pos`≥`NUM_DIGITS` are silently dropped.
  - A repeat write to the same position overwrites it.
- ERRO: buffer is cleared to blank every cycle.
  - Display override: position 2 shows E, positions 1 and 0 show r, all others blank.
  - The buffer is not written.
- PRONTA and OCUPADA: buffer holds its contents.
- OCUPADA: `dp` is lit (0) only while scanning position 0. In every other state `dp`=1.
- Scanner:
  - `div_cnt` counts 0..`REFRESH_DIV`-1 and wraps.
  - On wrap, `scan_idx` advances, from `NUM_DIGITS`-1 back to 0.
  - `an` is low only at bit `scan_idx`.
- Segment patterns, {g..a}, active-low:
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
  - minus:0111111, blank:1111111, E:0000110, r:0101111
- Out-of-range `dig` values (B–F) display blank; they are never errors.

## Timing
- Reset values:
  - `an` all ones, `seg`=1111111, `dp`=1.
  - `div_cnt`=0, `scan_idx`=0, buffer all blank.
- `an`, `seg` and `dp` are registered.
- A buffer write on edge N appears on `seg` at edge N+1 if that position is being scanned at N+1.
- `scan_idx` change on edge N: `an`/`seg` reflect the new index at edge N+1.
- ERRO override: takes effect on `seg` one edge after `status` becomes 00.
- Reset mid-frame clears everything on that edge; the next IMPRIME starts a new frame.
- `REFRESH_DIV`=1: `scan_idx` advances every cycle.

## Configuration
- `DISPLAY_SCAN_LZB_EN` defined: leading-zero blanking. A position i>0 holding 0 displays blank when every position >i holds 0 or a blank code. Position 0 always displays. Minus is non-zero for this rule.
- Undefined: every code displays exactly as stored.
- Blanking is evaluated on the buffer contents at the output register's input; it adds no latency.

## Structure
- `calc_pkg`, shared with the core:
  - status enum (ERRO, PRONTA, OCUPADA, IMPRIME).
  - Digit-code constants `DIG_MINUS`=4'hA and `DIG_BLANK`=4'hF.
  - Segment-pattern constants, including E and r.
- Sub-module `seg7_decoder`: combinational, 4-bit code in, 7-bit pattern out. Instantiated once, at the scan mux output.

## Test plan
- Reset, then hold 5 cycles → `an`=8'hFF, `seg`=7'h7F, `dp`=1.
- `REFRESH_DIV`=4. IMPRIME frame writes pos0=3, pos1=2, then status PRONTA → scanning position 0 gives `seg`=0110000; position 1 gives 0100100; positions 2–7 blank. `an` advances every 4 cycles and wraps 7→0.
- Second IMPRIME frame writing only pos0=7 → position 1 is now blank (frame clear). Repeat write pos0=1 in the same frame → position 0 shows 1111001.
- Write `pos`=9 with `NUM_DIGITS`=8 → buffer unchanged; no `an` bit other than the scanned one is ever low.
- `status`=00 → positions 2/1/0 show E/r/r one edge later. Returning to PRONTA shows all blank.
- With `DISPLAY_SCAN_LZB_EN`, frame pos2=0, pos1=0, pos0=0 → positions 2 and 1 blank, position 0 shows 0. Frame pos2=5, pos1=0 → position 1 shows 0. OCUPADA → `dp`=0 only while `scan_idx`=0.
